// File: rtl/clock_set_ctrl_pkg.sv
// clock_pkg: shared types and constants for the clock set controller and
// the time counters it drives.
package clock_pkg;

  // Controller mode, also exported on the mode output.
  typedef enum logic [1:0] {
    RUN      = 2'd0,
    SET_HOUR = 2'd1,
    SET_MIN  = 2'd2
  } mode_t;

  // Field moduli of the seconds/minutes/hours counter chain.
  localparam int unsigned SEC_MAX  = 60;
  localparam int unsigned MIN_MAX  = 60;
  localparam int unsigned HOUR_MAX = 24;

  // Mode button cycles RUN -> SET_HOUR -> SET_MIN -> RUN.
  function automatic mode_t advance_mode(input mode_t m);
    case (m)
      RUN:      return SET_HOUR;
      SET_HOUR: return SET_MIN;
      default:  return RUN;
    endcase
  endfunction

endpackage

// File: rtl/clock_set_ctrl_button_event.sv
// button_event: turns a debounced button level into single-cycle events.
// The event is registered, so it appears one cycle after the rising edge
// is sampled. The previous-level register resets to 1 so a button held
// through reset never produces an event.
// Optional feature: CLOCK_AUTOREPEAT_EN adds hold-to-repeat events when
// REPEAT_EN is set on the instance; without the macro the repeat logic
// does not exist and the REPEAT_* parameters have no effect.
module button_event
  import clock_pkg::*;
#(
  parameter bit          REPEAT_EN     = 1'b0,
  parameter int unsigned REPEAT_DELAY  = 4,
  parameter int unsigned REPEAT_PERIOD = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic evt_o
);

  logic btn_q;
  logic evt_q;
  logic evt_d;
  logic rise;

  assign rise = btn_i & ~btn_q;

`ifdef CLOCK_AUTOREPEAT_EN
  localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RCNT_W  = (RPT_MAX > 1) ? $clog2(RPT_MAX) : 1;

  logic rpt_evt;

  if (REPEAT_EN) begin : g_rpt
    logic [RCNT_W-1:0] rcnt_q, rcnt_d;
    logic              armed_q, armed_d;

    // Countdown to the next repeat; only armed by a genuine press so a
    // button held through reset never auto-repeats.
    always_comb begin
      rcnt_d  = rcnt_q;
      armed_d = armed_q;
      rpt_evt = 1'b0;
      if (!btn_i) begin
        rcnt_d  = '0;
        armed_d = 1'b0;
      end else if (rise) begin
        rcnt_d  = RCNT_W'(REPEAT_DELAY - 1);
        armed_d = 1'b1;
      end else if (armed_q) begin
        if (rcnt_q == '0) begin
          rpt_evt = 1'b1;
          rcnt_d  = RCNT_W'(REPEAT_PERIOD - 1);
        end else begin
          rcnt_d = rcnt_q - RCNT_W'(1);
        end
      end
    end

    // Repeat counter state.
    always_ff @(posedge clk) begin
      if (!rst) begin
        rcnt_q  <= '0;
        armed_q <= 1'b0;
      end else begin
        rcnt_q  <= rcnt_d;
        armed_q <= armed_d;
      end
    end
  end else begin : g_norpt
    assign rpt_evt = 1'b0;
  end

  assign evt_d = rise | rpt_evt;
`else
  assign evt_d = rise;
`endif

  // Edge register and registered event pulse.
  always_ff @(posedge clk) begin
    if (!rst) begin
      btn_q <= 1'b1;
      evt_q <= 1'b0;
    end else begin
      btn_q <= btn_i;
      evt_q <= evt_d;
    end
  end

  assign evt_o = evt_q;

endmodule

// File: rtl/clock_set_ctrl.sv
// clock_set_ctrl: 1 Hz prescaler, counter-chain sequencing and the
// hour/minute setting FSM with idle timeout and field blinking.
// Optional feature: CLOCK_AUTOREPEAT_EN enables hold-to-repeat on btn_inc.
// All pulse and blank outputs are forced low while rst is asserted.
module clock_set_ctrl
  import clock_pkg::*;
#(
  parameter int unsigned CLK_HZ        = 50_000_000,
  parameter int unsigned TIMEOUT_S     = 10,
  parameter int unsigned REPEAT_DELAY  = CLK_HZ / 2,
  parameter int unsigned REPEAT_PERIOD = CLK_HZ / 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic       sec_rollover,
  input  logic       min_rollover,
  output logic       inc_sec,
  output logic       inc_min,
  output logic       inc_hour,
  output logic       sec_clr,
  output logic [1:0] mode,
  output logic       blank_hour,
  output logic       blank_min,
  output logic       tick_1hz
);

  localparam int unsigned PCNT_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int unsigned TCNT_W = $clog2(TIMEOUT_S + 1);

  localparam logic [PCNT_W-1:0] P_LAST = PCNT_W'(CLK_HZ - 1);
  localparam logic [PCNT_W-1:0] P_HALF = PCNT_W'(CLK_HZ / 2 - 1);
  localparam logic [TCNT_W-1:0] T_LAST = TCNT_W'(TIMEOUT_S - 1);

  logic              evt_mode;
  logic              inc_evt;

  mode_t             state_q, state_d;
  logic [PCNT_W-1:0] pcnt_q, pcnt_d;
  logic [TCNT_W-1:0] tcnt_q, tcnt_d;
  logic              blink_q, blink_d;

  logic              tick_raw;
  logic              in_set;
  logic              timeout;
  logic              go_run;

  button_event #(
    .REPEAT_EN     (1'b0),
    .REPEAT_DELAY  (REPEAT_DELAY),
    .REPEAT_PERIOD (REPEAT_PERIOD)
  ) u_btn_mode (
    .clk   (clk),
    .rst   (rst),
    .btn_i (btn_mode),
    .evt_o (evt_mode)
  );

  button_event #(
    .REPEAT_EN     (1'b1),
    .REPEAT_DELAY  (REPEAT_DELAY),
    .REPEAT_PERIOD (REPEAT_PERIOD)
  ) u_btn_inc (
    .clk   (clk),
    .rst   (rst),
    .btn_i (btn_inc),
    .evt_o (inc_evt)
  );

  assign tick_raw = (pcnt_q == P_LAST);
  assign in_set   = (state_q != RUN);

  // Idle expiry lands on the tick that would bring tcnt to TIMEOUT_S; an
  // increment in the same cycle restarts the idle period instead.
  assign timeout  = in_set & tick_raw & ~inc_evt & (tcnt_q == T_LAST);

  // Next mode: a mode edge always advances exactly one step and so takes
  // precedence over a simultaneous timeout.
  always_comb begin
    state_d = state_q;
    if (evt_mode) begin
      state_d = advance_mode(state_q);
    end else if (timeout) begin
      state_d = RUN;
    end
  end

  assign go_run = in_set & (state_d == RUN);

  // Next values for prescaler, idle counter and blink phase.
  always_comb begin
    pcnt_d = pcnt_q + PCNT_W'(1);
    if (go_run || tick_raw) begin
      pcnt_d = '0;
    end

    tcnt_d = tcnt_q;
    if (!in_set || evt_mode || inc_evt) begin
      tcnt_d = '0;
    end else if (tick_raw) begin
      tcnt_d = tcnt_q + TCNT_W'(1);
    end

    blink_d = blink_q;
    if (inc_evt) begin
      blink_d = 1'b0;
    end else if (pcnt_q == P_HALF || tick_raw) begin
      blink_d = ~blink_q;
    end
  end

  // Free-running 1 Hz prescaler, realigned on every return to RUN.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pcnt_q <= '0;
    end else begin
      pcnt_q <= pcnt_d;
    end
  end

  // Mode FSM with its idle timer and blink phase.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= RUN;
      tcnt_q  <= '0;
      blink_q <= 1'b0;
    end else begin
      state_q <= state_d;
      tcnt_q  <= tcnt_d;
      blink_q <= blink_d;
    end
  end

  // Increment routing: the counter chain in RUN, the selected field while
  // setting. Minute wraps never reach the hours outside RUN.
  always_comb begin
    inc_sec  = 1'b0;
    inc_min  = 1'b0;
    inc_hour = 1'b0;
    if (rst) begin
      case (state_q)
        RUN: begin
          inc_sec  = tick_raw;
          inc_min  = sec_rollover;
          inc_hour = min_rollover;
        end
        SET_HOUR: inc_hour = inc_evt;
        SET_MIN:  inc_min  = inc_evt;
        default: ;
      endcase
    end
  end

  assign sec_clr    = rst & go_run;
  assign tick_1hz   = rst & tick_raw;
  assign blank_hour = rst & (state_q == SET_HOUR) & blink_q;
  assign blank_min  = rst & (state_q == SET_MIN) & blink_q;
  assign mode       = state_q;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Bench for clock_set_ctrl: directed sequence followed by random stimulus,
// every cycle compared against a behavioural model of the mode rules.
module tb_clock_set_ctrl;

  localparam int CLK_HZ    = 10;
  localparam int TIMEOUT_S = 3;
  localparam int RPT_DLY   = 5;
  localparam int RPT_PER   = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       btn_mode = 1'b0;
  logic       btn_inc = 1'b0;
  logic       sec_rollover = 1'b0;
  logic       min_rollover = 1'b0;
  logic       inc_sec, inc_min, inc_hour, sec_clr;
  logic [1:0] mode;
  logic       blank_hour, blank_min, tick_1hz;

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;
  int cycle   = 0;

  // Reference model state: mode as 0/1/2, prescaler phase, ticks idle in a
  // set state, cycles btn_inc has been held since its press (-1: not a press).
  int m_mode, m_p, m_idle, m_held;
  bit m_blink, m_bm_prev, m_bi_prev, m_mev, m_iev;

  always #5 clk = ~clk;

  clock_set_ctrl #(
    .CLK_HZ        (CLK_HZ),
    .TIMEOUT_S     (TIMEOUT_S),
    .REPEAT_DELAY  (RPT_DLY),
    .REPEAT_PERIOD (RPT_PER)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .btn_mode     (btn_mode),
    .btn_inc      (btn_inc),
    .sec_rollover (sec_rollover),
    .min_rollover (min_rollover),
    .inc_sec      (inc_sec),
    .inc_min      (inc_min),
    .inc_hour     (inc_hour),
    .sec_clr      (sec_clr),
    .mode         (mode),
    .blank_hour   (blank_hour),
    .blank_min    (blank_min),
    .tick_1hz     (tick_1hz)
  );

  function automatic bit rpt_due(input int held);
`ifdef CLOCK_AUTOREPEAT_EN
    return (held == RPT_DLY) || (held > RPT_DLY && ((held - RPT_DLY) % RPT_PER) == 0);
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_reset();
    m_mode = 0; m_p = 0; m_idle = 0; m_held = -1;
    m_blink = 0; m_bm_prev = 1; m_bi_prev = 1; m_mev = 0; m_iev = 0;
  endtask

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s cycle %0d: got %b expected %b", tag, cycle, obs, exp);
    end
  endtask

  // One clock: compare outputs mid-cycle, then advance the model.
  task automatic step();
    bit tick, evm, evi, set, tmo, es, em, eh, ec, ebh, ebm;
    int nm;
    @(negedge clk);
    if (!rst) begin
      check("inc_rst", {1'b0, inc_sec, inc_min, inc_hour}, 4'b0000);
      check("mode", {2'b00, mode}, 4'(m_mode));
      check("ctl_rst", {sec_clr, blank_hour, blank_min, tick_1hz}, 4'b0000);
      model_reset();
    end else begin
      tick = (m_p == CLK_HZ - 1);
      evm  = m_mev;
      evi  = m_iev;
      set  = (m_mode != 0);
      es   = !set && tick;
      em   = set ? (m_mode == 2 && evi) : sec_rollover;
      eh   = set ? (m_mode == 1 && evi) : min_rollover;
      tmo  = set && tick && !evi && (m_idle + 1 == TIMEOUT_S);
      nm   = evm ? (m_mode + 1) % 3 : (tmo ? 0 : m_mode);
      ec   = set && (nm == 0);
      ebh  = (m_mode == 1) && m_blink;
      ebm  = (m_mode == 2) && m_blink;
      check("inc", {1'b0, inc_sec, inc_min, inc_hour}, {1'b0, es, em, eh});
      check("mode", {2'b00, mode}, 4'(m_mode));
      check("ctl", {sec_clr, blank_hour, blank_min, tick_1hz}, {ec, ebh, ebm, tick});

      if (evi) m_blink = 0;
      else if (m_p == CLK_HZ / 2 - 1 || tick) m_blink = !m_blink;
      if (!set || evm || evi) m_idle = 0;
      else if (tick) m_idle++;
      m_p    = ec ? 0 : (m_p + 1) % CLK_HZ;
      m_mode = nm;
      m_mev  = btn_mode && !m_bm_prev;
      m_bm_prev = btn_mode;
      if (btn_inc && !m_bi_prev) begin
        m_held = 0;
        m_iev  = 1;
      end else if (btn_inc && m_held >= 0) begin
        m_held++;
        m_iev = rpt_due(m_held);
      end else begin
        m_iev = 0;
        if (!btn_inc) m_held = -1;
      end
      m_bi_prev = btn_inc;
    end
    @(posedge clk);
    #1;
    cycle++;
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic run_rnd_roll(input int n);
    repeat (n) begin
      sec_rollover = ($urandom_range(0, 7) == 0);
      min_rollover = ($urandom_range(0, 7) == 0);
      step();
    end
    sec_rollover = 0;
    min_rollover = 0;
  endtask

  task automatic press_mode();
    btn_mode = 1; run(2);
    btn_mode = 0; run(2);
  endtask

  task automatic press_inc(input int hold);
    btn_inc = 1; run(hold);
    btn_inc = 0; run(3);
  endtask

  initial begin
    model_reset();
    rst = 0;
    btn_mode = 1;
    @(posedge clk);
    #1;
    run(3);                       // reset with mode button held
    rst = 1;
    run_rnd_roll(100);            // RUN: seconds ticks and chained rollovers
    btn_mode = 0; run(3);         // release: still no event
    press_mode();                 // -> SET_HOUR
    repeat (3) press_inc(1);
    press_mode();                 // -> SET_MIN
    min_rollover = 1;
    repeat (3) press_inc(1);      // minutes only, no hour despite rollover
    min_rollover = 0;
    press_mode();                 // -> RUN with sec_clr
    run(25);
    press_mode();                 // SET_HOUR, left idle
    run(45);
    press_mode();                 // SET_HOUR, inc press mid-idle
    run(15);
    press_inc(1);
    run(40);
    press_mode();                 // SET_HOUR, inc held
    press_inc(12);
    run(40);
    for (int g = 0; g < 2 * CLK_HZ && m_p != CLK_HZ - 2; g++) run(1);
    btn_mode = 1; run(2);         // mode event lands on the tick cycle
    btn_mode = 0; run(3);
    rst = 0; run(2);              // reset mid-set
    rst = 1; run(5);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0) btn_mode = !btn_mode;
      if ($urandom_range(0, 5) == 0) btn_inc = !btn_inc;
      sec_rollover = ($urandom_range(0, 5) == 0);
      min_rollover = ($urandom_range(0, 5) == 0);
      rst = ($urandom_range(0, 299) != 0);
      step();
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
